fetch_ctrl: RTL and testbench

Instruction fetch sequencer for the 32-bit MIPS core. Owns the program counter and drives the address port of the combinational-read instruction memory (32 words × 32 bit, word index = pc[6:2]). Captures each fetched word into a one-entry fetch buffer presented to decode with a valid/ready handshake. Handles branch/jump redirects, decode back-pressure, start/stop, and an optional halt on an all-zero word.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_buf.sv | 34 +++
 rtl/fetch_ctrl.sv | 97 +++++++++
 tb/tb_fetch_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] HALT_WORD    = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buf.sv
// One-entry fetch buffer between the sequencer and decode.
import fetch_pkg::*;

module fetch_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic        consume,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  // Flush wins; stale payload is kept when the entry is just consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_valid <= 1'b0;
      dec_instr <= 32'h0;
      dec_pc    <= 32'h0;
    end else if (flush) begin
      dec_valid <= 1'b0;
    end else if (load) begin
      dec_valid <= 1'b1;
      dec_instr <= instr;
      dec_pc    <= pc;
    end else if (consume) begin
      dec_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC, run/halt FSM, fetch buffer feed.
// Optional halt on all-zero word: define FETCH_HALT_ON_ZERO_EN.
import fetch_pkg::*;

module fetch_ctrl #(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        halted
);

  localparam logic [31:0] PC_MASK =
    32'((64'd1 << (ADDR_W + 2)) - 64'd1) & ~32'd3;

  state_t state;
  logic   free;
  logic   consume;
  logic   is_halt;
  logic   fetch_ok;
  logic   capture;
  logic   halt_go;

  assign consume  = dec_valid & dec_ready;
  assign free     = ~dec_valid | dec_ready;
  assign fetch_ok = (state == RUN) & free & ~redirect_valid;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign is_halt = (imem_instr == HALT_WORD);
`else
  assign is_halt = 1'b0;
`endif

  assign capture = fetch_ok & ~is_halt;
  assign halt_go = fetch_ok & is_halt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_pc <= RESET_PC;
    end else if (redirect_valid) begin
      imem_pc <= redirect_pc & PC_MASK;
    end else if (capture) begin
      imem_pc <= (imem_pc + PC_STEP) & PC_MASK;
    end
  end

  // A redirect in IDLE only moves the PC; HALT is left only by redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (enable && !redirect_valid) state <= RUN;
        RUN: begin
          if (!enable)      state <= IDLE;
          else if (halt_go) state <= HALT;
        end
        HALT: if (redirect_valid) state <= enable ? RUN : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_HALT_ON_ZERO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               halted <= 1'b0;
    else if (redirect_valid) halted <= 1'b0;
    else if (halt_go)        halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

  fetch_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (capture),
    .flush     (redirect_valid),
    .consume   (consume),
    .instr     (imem_instr),
    .pc        (imem_pc),
    .dec_valid (dec_valid),
    .dec_instr (dec_instr),
    .dec_pc    (dec_pc)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small combinational imem model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        halted;

  logic [31:0] imem [32];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign imem_instr = imem[imem_pc[6:2]];

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) imem[i] = 32'h1000_0000 + i;
    imem[0] = 32'h0232_8020;
    imem[1] = 32'h0232_8021;
    imem[8] = 32'h0000_0000;

    reset = 1'b1;
    enable = 1'b0;
    dec_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    #12;
    reset = 1'b0;
    chk("rst_pc", imem_pc, 32'h0);
    chk("rst_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_instr", dec_instr, 32'h0);
    chk("rst_decpc", dec_pc, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'd0);

    // Startup
    enable = 1'b1;
    step();
    chk("start_novalid", {31'b0, dec_valid}, 32'd0);
    chk("start_pc0", imem_pc, 32'h0);
    step();
    chk("start_v1", {31'b0, dec_valid}, 32'd1);
    chk("start_i1", dec_instr, 32'h0232_8020);
    chk("start_p1", dec_pc, 32'h0);
    chk("start_pc4", imem_pc, 32'h4);
    step();
    chk("start_i2", dec_instr, 32'h0232_8021);
    chk("start_p2", dec_pc, 32'h4);
    chk("start_pc8", imem_pc, 32'h8);

    // Back-pressure
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_instr", dec_instr, 32'h0232_8021);
      chk("bp_decpc", dec_pc, 32'h4);
      chk("bp_pc", imem_pc, 32'h8);
    end
    dec_ready = 1'b1;
    step();
    chk("bp_rel_decpc", dec_pc, 32'h8);
    chk("bp_rel_pc", imem_pc, 32'hC);

    // Redirect without consume
    dec_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_001F;
    step();
    redirect_valid = 1'b0;
    dec_ready = 1'b1;
    chk("rd_pc", imem_pc, 32'h1C);
    chk("rd_flush", {31'b0, dec_valid}, 32'd0);
    step();
    chk("rd_decpc", dec_pc, 32'h1C);
    chk("rd_valid", {31'b0, dec_valid}, 32'd1);
    chk("rd_pc2", imem_pc, 32'h20);

    // Redirect coincident with consume
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("rdc_pc", imem_pc, 32'h1C);
    chk("rdc_flush", {31'b0, dec_valid}, 32'd0);
    step();
    chk("rdc_decpc", dec_pc, 32'h1C);
    chk("rdc_instr", dec_instr, 32'h1000_0007);

    // Zero word at 0x20
    step();
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("hz_halted", {31'b0, halted}, 32'd1);
    chk("hz_pc", imem_pc, 32'h20);
    chk("hz_valid", {31'b0, dec_valid}, 32'd0);
    step();
    chk("hz_hold_pc", imem_pc, 32'h20);
    chk("hz_hold_h", {31'b0, halted}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("hz_clr", {31'b0, halted}, 32'd0);
    chk("hz_rpc", imem_pc, 32'h0);
    step();
    chk("hz_decpc", dec_pc, 32'h0);
    chk("hz_instr", dec_instr, 32'h0232_8020);
`else
    chk("nz_instr", dec_instr, 32'h0);
    chk("nz_decpc", dec_pc, 32'h20);
    chk("nz_pc", imem_pc, 32'h24);
    chk("nz_halted", {31'b0, halted}, 32'd0);
`endif

    // Wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'h78;
    step();
    redirect_valid = 1'b0;
    chk("wr_pc", imem_pc, 32'h78);
    step();
    chk("wr_d78", dec_pc, 32'h78);
    chk("wr_pc7c", imem_pc, 32'h7C);
    step();
    chk("wr_d7c", dec_pc, 32'h7C);
    chk("wr_pc0", imem_pc, 32'h0);
    step();
    chk("wr_d0", dec_pc, 32'h0);
    chk("wr_i0", dec_instr, 32'h0232_8020);
    chk("wr_pc4", imem_pc, 32'h4);

    // Async reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", {31'b0, dec_valid}, 32'd0);
    chk("ar_pc", imem_pc, 32'h0);
    #1;
    reset = 1'b0;
    step();
    chk("ar_idle", {31'b0, dec_valid}, 32'd0);
    step();
    chk("ar_i1", dec_instr, 32'h0232_8020);
    chk("ar_p1", dec_pc, 32'h0);
    step();
    chk("ar_i2", dec_instr, 32'h0232_8021);
    chk("ar_p2", dec_pc, 32'h4);
    chk("ar_pc8", imem_pc, 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
